fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the program counter and requests words from instruction memory over a req/ready handshake.
- Holds each returned word in an instruction register and presents it with a one-cycle-qualified decode_enable.
- Handles stall from downstream and PC redirect from the branch/execute stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0).
- TIMEOUT_CYCLES, 16, max cycles in S_REQ without imem_ready before fault (only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, high in S_REQ only.
- imem_addr  output  32  word address = pc, bits [1:0] always 0.
- imem_ready  input  1  memory accepts request and returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word, valid when imem_req & imem_ready.
- stall  input  1  downstream cannot accept the presented instruction.
- branch_taken  input  1  one-cycle redirect pulse.
- branch_target  input  32  new PC; bits [1:0] ignored (forced 0).
- instruction  output  32  registered instruction to decoder.
- instr_pc  output  32  address the instruction was fetched from.
- decode_enable  output  1  instruction valid for decoder this cycle.
- fetch_fault  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=S_REQ, instruction=0, instr_pc=0, fetch_fault=0, timeout counter=0.
  - Outputs follow state, so imem_req=1 and decode_enable=0 on the first cycle after release.
  - A reset asserted mid-fetch abandons any outstanding request; no data from that request is used.
- States: S_REQ, S_ISSUE, S_FAULT (S_FAULT reachable only with FETCH_TIMEOUT_EN).
- Output decode (combinational from state):
  - imem_req = (state==S_REQ).
  - imem_addr = pc.
  - decode_enable = (state==S_ISSUE) & ~stall & ~branch_taken.
- S_REQ:
  - If branch_taken: pc<=branch_target&~3, stay S_REQ, discard imem_rdata even if imem_ready=1.
  - Else if imem_ready: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4, go S_ISSUE.
  - Else hold; imem_req stays high and imem_addr stays stable until ready.
- S_ISSUE:
  - If branch_taken: pc<=branch_target&~3, drop the held instruction (decode_enable=0), go S_REQ.
  - Else if stall: stay, instruction/instr_pc unchanged, decode_enable=0.
  - Else: decoder consumes at this posedge, go S_REQ.
- Throughput: 2 cycles per instruction minimum (ready same cycle as req, no stall). Latency from imem_ready to decode_enable is 1 cycle.
- Priority: reset > branch_taken > imem_ready/stall. Branch and stall in the same cycle means branch wins.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000. No fault is raised on wrap.
- instr_pc is always the address the current instruction was fetched from, never pc.
- No outputs change in S_ISSUE except on branch; instruction/instr_pc stay stable while stalled.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle in S_REQ with imem_ready=0. It clears on ready, branch, or state exit.
  - When the counter reaches TIMEOUT_CYCLES: fetch_fault<=1, go S_FAULT.
  - S_FAULT: imem_req=0, decode_enable=0; branch_taken ignored; only rst_n exits.
- Without the macro: no counter or S_FAULT logic; fetch_fault tied 0; a memory that never readies stalls indefinitely in S_REQ.

Test Plan:
- Reset release, imem_ready=1 constantly, rdata=32'hE3A01005 at 0, 32'hE0812002 at 4 -> decode_enable pulses every other cycle; instruction/instr_pc = E3A01005/0, then E0812002/4; imem_addr sequence 0,4,8.
- imem_ready held low 3 cycles at pc=0x10 -> imem_req high with addr 0x10 stable for 4 cycles; one issue of instr_pc=0x10 after ready.
- Stall high 5 cycles in S_ISSUE with instruction=0xE5912000 -> decode_enable 0 throughout, instruction unchanged; one decode_enable pulse when stall drops; next imem_addr = instr_pc+4.
- branch_taken with target 0x103 while in S_ISSUE and stall=1 -> held instruction never enabled; next imem_addr=0x100. Repeat in S_REQ with imem_ready=1 the same cycle -> rdata discarded, imem_addr=0x100.
- RESET_VECTOR=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, next at 0000_0000; rst_n pulsed low while in S_REQ wait -> returns to S_REQ at RESET_VECTOR, no enable.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_ready stuck 0 -> fetch_fault=1 after 16 waiting cycles; imem_req=0; branch_taken ignored; rst_n clears. Without macro -> fetch_fault stays 0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, decoder-side issue and redirect/stall controls.
`timescale 1ns/1ps
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        decode_enable;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, decode_enable, fetch_fault,
    input  imem_ready, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, decode_enable, fetch_fault,
    output imem_ready, imem_rdata, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ready and issues one word at a time.
// Optional memory-timeout fault is enabled by defining FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_REQ, S_ISSUE, S_FAULT} state_t;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`else
  typedef enum logic [0:0] {S_REQ, S_ISSUE} state_t;
`endif

  if ((RESET_VECTOR[1:0] != 2'b00) || (TIMEOUT_CYCLES == 0)) begin : g_bad_param
    $error("fetch_unit: RESET_VECTOR must be word aligned and TIMEOUT_CYCLES nonzero");
  end

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] target_c;

  assign target_c = bus.branch_target & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      ipc_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Redirect beats memory response and stall; S_FAULT is left only by reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      S_REQ: begin
        if (bus.branch_taken) begin
          pc_d = target_c;
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + PC_STEP;
          state_d = S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_ISSUE: begin
        if (bus.branch_taken) begin
          pc_d    = target_c;
          state_d = S_REQ;
        end else if (!bus.stall) begin
          state_d = S_REQ;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  assign bus.imem_req      = (state_q == S_REQ);
  assign bus.imem_addr     = pc_q;
  assign bus.decode_enable = (state_q == S_ISSUE) & ~bus.stall & ~bus.branch_taken;
  assign bus.instruction   = instr_q;
  assign bus.instr_pc      = ipc_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_fault   = fault_q;
`else
  assign bus.fetch_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: issue cadence, memory wait, stall, redirect, PC wrap, reset, timeout.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   checks;
  int   errors;

  fetch_if bif ();
  fetch_if bif2 ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bif2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0000_0000: memw = 32'hE3A0_1005;
      32'h0000_0004: memw = 32'hE081_2002;
      32'h0000_0014: memw = 32'hE591_2000;
      default:       memw = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rdy, input logic stl, input logic br,
                     input logic [31:0] tgt, input logic [31:0] rd);
    bif.imem_ready    = rdy;
    bif.stall         = stl;
    bif.branch_taken  = br;
    bif.branch_target = tgt;
    bif.imem_rdata    = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bif.imem_ready = 1'b0;  bif.imem_rdata = '0;  bif.stall = 1'b0;
    bif.branch_taken = 1'b0; bif.branch_target = '0;
    bif2.imem_ready = 1'b0; bif2.imem_rdata = '0; bif2.stall = 1'b0;
    bif2.branch_taken = 1'b0; bif2.branch_target = '0;
    tick();
    tick();

    // Reset state
    chk("rst_req",   bif.imem_req, 1'b1);
    chk("rst_addr",  bif.imem_addr, 32'h0);
    chk("rst_de",    bif.decode_enable, 1'b0);
    chk("rst_instr", bif.instruction, 32'h0);
    chk("rst_ipc",   bif.instr_pc, 32'h0);
    chk("rst_fault", bif.fetch_fault, 1'b0);
    chk("rst2_addr", bif2.imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Back-to-back fetch with memory always ready
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t1_addr0", bif.imem_addr, 32'h0);
    chk("t1_req0",  bif.imem_req, 1'b1);
    chk("t1_de0",   bif.decode_enable, 1'b0);
    tick();
    drv(1, 0, 0, 0, 32'h0);
    chk("t1_de1",    bif.decode_enable, 1'b1);
    chk("t1_instr1", bif.instruction, 32'hE3A0_1005);
    chk("t1_ipc1",   bif.instr_pc, 32'h0);
    chk("t1_req1",   bif.imem_req, 1'b0);
    tick();
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t1_addr4", bif.imem_addr, 32'h4);
    chk("t1_de2",   bif.decode_enable, 1'b0);
    tick();
    drv(1, 0, 0, 0, 32'h0);
    chk("t1_de3",    bif.decode_enable, 1'b1);
    chk("t1_instr3", bif.instruction, 32'hE081_2002);
    chk("t1_ipc3",   bif.instr_pc, 32'h4);
    tick();
    for (int a = 8; a <= 12; a += 4) begin
      drv(1, 0, 0, 0, memw(bif.imem_addr));
      chk("t1_addr", bif.imem_addr, 32'(a));
      tick();
      drv(1, 0, 0, 0, 32'h0);
      chk("t1_ipc", bif.instr_pc, 32'(a));
      chk("t1_de",  bif.decode_enable, 1'b1);
      tick();
    end

    // Memory not ready for 3 cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 32'hBAD0_0000);
      chk("t2_wait_req",  bif.imem_req, 1'b1);
      chk("t2_wait_addr", bif.imem_addr, 32'h10);
      chk("t2_wait_de",   bif.decode_enable, 1'b0);
      tick();
    end
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t2_rdy_addr", bif.imem_addr, 32'h10);
    tick();
    drv(1, 0, 0, 0, 32'h0);
    chk("t2_de",    bif.decode_enable, 1'b1);
    chk("t2_ipc",   bif.instr_pc, 32'h10);
    chk("t2_instr", bif.instruction, memw(32'h10));
    tick();

    // Stall held for 5 cycles in issue
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t3_addr", bif.imem_addr, 32'h14);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 0, 0, 32'h0);
      chk("t3_stall_de",    bif.decode_enable, 1'b0);
      chk("t3_stall_instr", bif.instruction, 32'hE591_2000);
      chk("t3_stall_ipc",   bif.instr_pc, 32'h14);
      chk("t3_stall_req",   bif.imem_req, 1'b0);
      tick();
    end
    drv(1, 0, 0, 0, 32'h0);
    chk("t3_release_de", bif.decode_enable, 1'b1);
    tick();
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t3_next_addr", bif.imem_addr, 32'h18);
    tick();

    // Redirect while stalled in issue, then redirect racing a ready response
    drv(1, 1, 1, 32'h103, 32'h0);
    chk("t4_br_issue_de", bif.decode_enable, 1'b0);
    tick();
    drv(1, 0, 1, 32'h103, 32'hDEAD_BEEF);
    chk("t4_br_addr", bif.imem_addr, 32'h100);
    chk("t4_br_req",  bif.imem_req, 1'b1);
    chk("t4_br_de",   bif.decode_enable, 1'b0);
    tick();
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    chk("t4_stay_addr", bif.imem_addr, 32'h100);
    chk("t4_stay_req",  bif.imem_req, 1'b1);
    tick();
    drv(1, 0, 0, 0, 32'h0);
    chk("t4_de",    bif.decode_enable, 1'b1);
    chk("t4_ipc",   bif.instr_pc, 32'h100);
    chk("t4_instr", bif.instruction, 32'hA5A5_0100);
    tick();

    // Memory never ready at 0x104
    for (int i = 0; i < 15; i++) begin
      drv(0, 0, 0, 0, 32'h0);
      tick();
    end
    chk("t6_pre_fault", bif.fetch_fault, 1'b0);
    chk("t6_pre_req",   bif.imem_req, 1'b1);
    tick();
`ifdef FETCH_TIMEOUT_EN
    chk("t6_fault", bif.fetch_fault, 1'b1);
    chk("t6_req",   bif.imem_req, 1'b0);
    chk("t6_de",    bif.decode_enable, 1'b0);
    drv(1, 0, 1, 32'h200, 32'h0);
    tick();
    chk("t6_br_addr",  bif.imem_addr, 32'h104);
    chk("t6_br_fault", bif.fetch_fault, 1'b1);
    chk("t6_br_req",   bif.imem_req, 1'b0);
    drv(0, 0, 0, 0, 32'h0);
`else
    chk("t6_nofault",  bif.fetch_fault, 1'b0);
    chk("t6_wait_req", bif.imem_req, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_nofault_late", bif.fetch_fault, 1'b0);
    chk("t6_wait_addr",    bif.imem_addr, 32'h104);
`endif
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fault", bif.fetch_fault, 1'b0);
    chk("t6_rst_req",   bif.imem_req, 1'b1);
    chk("t6_rst_addr",  bif.imem_addr, 32'h0);
    chk("t6_rst_de",    bif.decode_enable, 1'b0);
    tick();
    rst_n = 1'b1;
    drv(1, 0, 0, 0, memw(bif.imem_addr));
    tick();
    drv(1, 0, 0, 0, 32'h0);
    chk("t6_after_de",  bif.decode_enable, 1'b1);
    chk("t6_after_ipc", bif.instr_pc, 32'h0);

    // PC wrap from the top of memory and reset during a wait
    rst2_n = 1'b1;
    bif2.imem_ready = 1'b1;
    bif2.imem_rdata = 32'h1111_1111;
    #1;
    chk("t5_addr_top", bif2.imem_addr, 32'hFFFF_FFFC);
    chk("t5_req_top",  bif2.imem_req, 1'b1);
    tick();
    chk("t5_de",    bif2.decode_enable, 1'b1);
    chk("t5_ipc",   bif2.instr_pc, 32'hFFFF_FFFC);
    chk("t5_instr", bif2.instruction, 32'h1111_1111);
    tick();
    chk("t5_wrap_addr", bif2.imem_addr, 32'h0);
    bif2.imem_ready = 1'b0;
    tick();
    tick();
    chk("t5_wait_addr", bif2.imem_addr, 32'h0);
    chk("t5_wait_req",  bif2.imem_req, 1'b1);
    rst2_n = 1'b0;
    bif2.imem_ready = 1'b1;
    bif2.imem_rdata = 32'h2222_2222;
    #1;
    chk("t5_rst_addr", bif2.imem_addr, 32'hFFFF_FFFC);
    chk("t5_rst_req",  bif2.imem_req, 1'b1);
    chk("t5_rst_de",   bif2.decode_enable, 1'b0);
    chk("t5_rst_ipc",  bif2.instr_pc, 32'h0);
    tick();
    rst2_n = 1'b1;
    #1;
    chk("t5_rel_addr", bif2.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_rel_ipc",   bif2.instr_pc, 32'hFFFF_FFFC);
    chk("t5_rel_instr", bif2.instruction, 32'h2222_2222);
    chk("t5_rel_de",    bif2.decode_enable, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
